ptd_bank: RTL

PTD_BANK -- requirements
Module: ptd_bank

---
 rtl/ptd_bank_if.sv | 26 ++
 rtl/ptd_bank.sv | 107 ++++++++++
 2 files changed

// File: rtl/ptd_bank_if.sv
// Bus bundle for the pulse-detector bank.
// The controller side is the master and drives the control and raw inputs.
// The bank is the slave and returns strobes, levels and the event count.
interface ptd_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic                en;
  logic [1:0]          mode;
  logic                clr;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] pulse_out;
  logic [CHANNELS-1:0] level;
  logic                event_any;
  logic [CNT_W-1:0]    event_count;

  modport master (
    output en, mode, clr, pulse,
    input  pulse_out, level, event_any, event_count
  );

  modport slave (
    input  en, mode, clr, pulse,
    output pulse_out, level, event_any, event_count
  );
endinterface

// File: rtl/ptd_bank.sv
// Bank of independent pulse channels.
// Each channel is processed in four steps:
//   1. Synchronise the raw input.
//   2. Debounce it into a stable level.
//   3. Qualify level edges against en/mode.
//   4. Emit a one-cycle strobe in the cycle after the level changes.
// A shared saturating counter tallies the strobes.
module ptd_bank #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input logic        clk,
  input logic        rst_n,
  ptd_bank_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(CHANNELS + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_ff [CHANNELS];
  logic [DW-1:0]          db_cnt  [CHANNELS];
  logic [CHANNELS-1:0]    level_r;
  logic [CHANNELS-1:0]    pend;
  logic [CHANNELS-1:0]    pulse_out_r;
  logic                   event_any_r;
  logic [CNT_W-1:0]       count_r;

  logic [CHANNELS-1:0]    sync_bit;
  logic [CHANNELS-1:0]    accept;
  logic                   rise_ok;
  logic                   fall_ok;
  logic [PW-1:0]          n_strobe;
  logic [SW-1:0]          sum;

  // Edge qualification uses en/mode as they are on the edge where the level flips.
  // The qualified result is parked in pend and becomes pulse_out one edge later.
  always_comb begin
    rise_ok  = bus.en && ((bus.mode == 2'b00) || (bus.mode == 2'b10));
    fall_ok  = bus.en && ((bus.mode == 2'b01) || (bus.mode == 2'b10));
    sync_bit = '0;
    accept   = '0;
    n_strobe = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_bit[i] = sync_ff[i][SYNC_STAGES-1];
      accept[i]   = (sync_bit[i] != level_r[i]) && (db_cnt[i] == DB_LAST) &&
                    (sync_bit[i] ? rise_ok : fall_ok);
      n_strobe    = n_strobe + PW'(pend[i]);
    end
    sum = SW'(count_r) + SW'(n_strobe);
  end

  // Per-channel synchroniser, debounce counter and accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_ff[i] <= '0;
        db_cnt[i]  <= '0;
      end
      level_r <= '0;
      pend    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_ff[i] <= {sync_ff[i][SYNC_STAGES-2:0], bus.pulse[i]};
        if (sync_bit[i] == level_r[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_r[i] <= sync_bit[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      pend <= accept;
    end
  end

  // Strobe outputs and saturating event counter.
  // The counter updates on the same edge that raises pulse_out.
  // A clear wins over any strobes arriving on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_out_r <= '0;
      event_any_r <= 1'b0;
      count_r     <= '0;
    end else begin
      pulse_out_r <= pend;
      event_any_r <= |pend;
      if (bus.clr)
        count_r <= '0;
      else if (sum > SW'(CNT_MAX))
        count_r <= CNT_MAX;
      else
        count_r <= sum[CNT_W-1:0];
    end
  end

  assign bus.pulse_out   = pulse_out_r;
  assign bus.level       = level_r;
  assign bus.event_any   = event_any_r;
  assign bus.event_count = count_r;

endmodule
